// File: rtl/uart_frame_loader.sv
// uart_frame_loader: turns received UART bytes into 3-bit RGB framebuffer writes.
// Good bytes fill pixels 0..NUM_PIXELS-1 in order. Bytes with a framing error
// are dropped and counted. A long mid-frame gap abandons the partial frame.
module uart_frame_loader #(
  parameter int unsigned NUM_PIXELS     = 76800,
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_error,
  output logic              wr_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [2:0]        wr_data,
  output logic              frame_done,
  output logic              timeout,
  output logic              busy,
  output logic [ERR_W-1:0]  err_count,
  output logic [7:0]        last_byte
);

  localparam int unsigned       CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  IDLE_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_ptr, w_ptr_next;       // next pixel address to be written
  logic [CNT_W-1:0]  r_idle, w_idle_next;     // idle cycles since last rx_valid in LOAD

  logic              w_good, w_bad;
  logic              w_wr_en, w_frame_done, w_timeout, w_busy;
  logic [ADDR_W-1:0] w_write_addr;
  logic [2:0]        w_wr_data;
  logic [ERR_W-1:0]  w_err_count;
  logic [7:0]        w_last_byte;

  assign w_good = rx_valid & ~rx_frame_error;
  assign w_bad  = rx_valid &  rx_frame_error;

  // State, pointer and idle counter registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_idle  <= w_idle_next;
    end
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_idle_next  = r_idle;
    w_wr_en      = 1'b0;
    w_write_addr = r_ptr;
    w_wr_data    = wr_data;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    w_err_count  = err_count;
    w_last_byte  = last_byte;

    if (rx_valid) begin
      w_idle_next = '0;
    end

    if (w_bad && (err_count != ERR_MAX)) begin
      w_err_count = err_count + 1'b1;
    end

    if (w_good) begin
      // r_ptr is 0 in IDLE, so one path covers the first and later pixels
      w_wr_en     = 1'b1;
      w_wr_data   = rx_data[2:0];
      w_last_byte = rx_data;
      if (r_ptr == LAST_ADDR) begin
        w_frame_done = 1'b1;
        w_ptr_next   = '0;
        w_state_next = S_IDLE;
      end else begin
        w_ptr_next   = r_ptr + 1'b1;
        w_state_next = S_LOAD;
      end
    end else if (!rx_valid) begin
      case (r_state)
        S_LOAD: begin
          if (r_idle == IDLE_TERM) begin
            w_timeout    = 1'b1;
            w_ptr_next   = '0;
            w_write_addr = '0;
            w_idle_next  = '0;
            w_state_next = S_IDLE;
          end else begin
            w_idle_next = r_idle + 1'b1;
          end
        end
        default: w_idle_next = '0;
      endcase
    end

    w_busy = (w_state_next == S_LOAD);
  end

  // Output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_en      <= 1'b0;
      write_addr <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      err_count  <= '0;
      last_byte  <= '0;
    end else begin
      wr_en      <= w_wr_en;
      write_addr <= w_write_addr;
      wr_data    <= w_wr_data;
      frame_done <= w_frame_done;
      timeout    <= w_timeout;
      busy       <= w_busy;
      err_count  <= w_err_count;
      last_byte  <= w_last_byte;
    end
  end

endmodule
